// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: bus layouts, load opcode bits, FSM encodings.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 81;
    localparam int MEM_TO_WB_WD = 70;
    localparam int MEM_FWD_WD   = 38;
    localparam int STALL_WD     = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // mem_op is one-hot {lb,lbu,lh,lhu,lw}
    localparam int OP_LB  = 4;
    localparam int OP_LBU = 3;
    localparam int OP_LH  = 2;
    localparam int OP_LHU = 1;
    localparam int OP_LW  = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef struct packed {
        logic [4:0]  mem_op;
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_wb_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_fwd_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Little-endian byte/half/word extraction with sign or zero extension for loads.
// Purely combinational; an opcode with no load bit set yields zero.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [4:0]  mem_op,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? word[31:16] : word[15:0];
        data     = '0;
        if (mem_op[OP_LB])
            data = {{24{byte_sel[7]}}, byte_sel};
        else if (mem_op[OP_LBU])
            data = {24'd0, byte_sel};
        else if (mem_op[OP_LH])
            data = {{16{half_sel[15]}}, half_sel};
        else if (mem_op[OP_LHU])
            data = {16'd0, half_sel};
        else if (mem_op[OP_LW])
            data = word;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the EX bus, waits for/holds the SRAM load word, produces WB and bypass buses.
// Outputs are combinational from the input register, FSM and hold buffer.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter bit SYNC_SRAM = 1'b1,
    parameter int STALL_IDX = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    input  logic                    data_sram_data_ok,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_FWD_WD-1:0]   mem_fwd_bus,
    output logic                    stallreq_for_mem
);

    ex_mem_t     ex_mem_r;
    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [31:0] hold_buf;
    logic        stage_stop;
    logic        next_stop;
    logic        is_load;
    logic        data_present;
    logic [31:0] load_word;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        unused_stall;

    assign unused_stall = ^stall;
    assign stage_stop   = (stall[STALL_IDX] == STOP);
    assign next_stop    = (stall[STALL_IDX+1] == STOP);

    always_ff @(posedge clk) begin
        if (rst)
            ex_mem_r <= '0;
        else if (stage_stop && !next_stop)
            ex_mem_r <= '0;
        else if (!stage_stop)
            ex_mem_r <= ex_mem_t'(ex_to_mem_bus);
    end

    assign is_load      = ex_mem_r.ram_en && (ex_mem_r.ram_wen == 4'd0) && (|ex_mem_r.mem_op);
    assign data_present = SYNC_SRAM ? 1'b1 : data_sram_data_ok;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (is_load && !data_present)
                    next_state = ST_WAIT;
                else if (is_load && stage_stop)
                    next_state = ST_HOLD;
            end
            ST_WAIT: begin
                if (data_present)
                    next_state = stage_stop ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!stage_stop)
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // The word is captured on entry to HOLD so SRAM may move on while the pipeline is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold_buf <= '0;
        end else begin
            state <= next_state;
            if (next_state == ST_HOLD && state != ST_HOLD)
                hold_buf <= data_sram_rdata;
            else if (state == ST_HOLD && next_state != ST_HOLD)
                hold_buf <= '0;
        end
    end

    assign stallreq_for_mem = ((state == ST_IDLE) && is_load && !data_present) ||
                              ((state == ST_WAIT) && !data_present);

    assign load_word = (state == ST_HOLD) ? hold_buf : data_sram_rdata;

    mem_stage_load_align u_align (
        .word   (load_word),
        .addr   (ex_mem_r.ex_result[1:0]),
        .mem_op (ex_mem_r.mem_op),
        .data   (load_data)
    );

    assign rf_wdata = ex_mem_r.sel_rf_res ? load_data : ex_mem_r.ex_result;

    mem_wb_t  wb;
    mem_fwd_t fwd;

    always_comb begin
        wb.pc        = ex_mem_r.pc;
        wb.rf_we     = ex_mem_r.rf_we;
        wb.rf_waddr  = ex_mem_r.rf_waddr;
        wb.rf_wdata  = rf_wdata;
        // Decode must not bypass a load result that has not arrived yet.
        fwd.rf_we    = ex_mem_r.rf_we && !stallreq_for_mem;
        fwd.rf_waddr = ex_mem_r.rf_waddr;
        fwd.rf_wdata = rf_wdata;
    end

    assign mem_to_wb_bus = wb;
    assign mem_fwd_bus   = fwd;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench: one synchronous-SRAM and one handshake-SRAM instance, hand-computed expectations.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [80:0] bus_s, bus_a;
    logic [31:0] rdata;
    logic        data_ok;
    logic [69:0] wb_s, wb_a;
    logic [37:0] fwd_s, fwd_a;
    logic        sreq_s, sreq_a;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage #(.SYNC_SRAM(1'b1), .STALL_IDX(3)) u_sync (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .ex_to_mem_bus     (bus_s),
        .data_sram_rdata   (rdata),
        .data_sram_data_ok (data_ok),
        .mem_to_wb_bus     (wb_s),
        .mem_fwd_bus       (fwd_s),
        .stallreq_for_mem  (sreq_s)
    );

    mem_stage #(.SYNC_SRAM(1'b0), .STALL_IDX(3)) u_async (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .ex_to_mem_bus     (bus_a),
        .data_sram_rdata   (rdata),
        .data_sram_data_ok (data_ok),
        .mem_to_wb_bus     (wb_a),
        .mem_fwd_bus       (fwd_a),
        .stallreq_for_mem  (sreq_a)
    );

    task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [80:0] mk(input logic [4:0] op, input logic en, input logic [3:0] wen,
                                       input logic sel, input logic we, input logic [4:0] wa,
                                       input logic [31:0] res, input logic [31:0] pc);
        return {op, pc, en, wen, sel, we, wa, res};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    localparam logic [4:0] LB = 5'b10000, LBU = 5'b01000, LH = 5'b00100, LHU = 5'b00010, LW = 5'b00001;

    initial begin
        rst = 1'b1; stall = 6'd0; bus_s = '0; bus_a = '0; rdata = '0; data_ok = 1'b0;
        tick(); tick();
        sample();
        check_val("rst_wb_s", 80'(wb_s), 80'd0);
        check_val("rst_fwd_s", 80'(fwd_s), 80'd0);
        check_val("rst_sreq_s", 80'(sreq_s), 80'd0);
        check_val("rst_wb_a", 80'(wb_a), 80'd0);
        check_val("rst_sreq_a", 80'(sreq_a), 80'd0);
        rst = 1'b0;

        // sync: lb byte 1 of 1234_80FF
        tick();
        bus_s = mk(LB, 1'b1, 4'd0, 1'b1, 1'b1, 5'd3, 32'h0000_1001, 32'h0000_0100);
        rdata = 32'h1234_80FF;
        tick(); sample();
        check_val("lb_data", 80'(wb_s[31:0]), 80'h FFFF_FF80);
        check_val("lb_we", 80'(wb_s[37]), 80'd1);
        check_val("lb_sreq", 80'(sreq_s), 80'd0);
        check_val("lb_pc", 80'(wb_s[69:38]), 80'h100);
        check_val("lb_fwd_we", 80'(fwd_s[37]), 80'd1);

        tick();
        bus_s = mk(LBU, 1'b1, 4'd0, 1'b1, 1'b1, 5'd3, 32'h0000_1003, 32'h0000_0104);
        tick(); sample();
        check_val("lbu_data", 80'(wb_s[31:0]), 80'h12);

        tick();
        bus_s = mk(LW, 1'b1, 4'd0, 1'b1, 1'b1, 5'd3, 32'h0000_1003, 32'h0000_0108);
        tick(); sample();
        check_val("lw_unaligned", 80'(wb_s[31:0]), 80'h1234_80FF);

        tick();
        rdata = 32'h8001_0000;
        bus_s = mk(LHU, 1'b1, 4'd0, 1'b1, 1'b1, 5'd4, 32'h0000_2002, 32'h0000_010C);
        tick(); sample();
        check_val("lhu_data", 80'(wb_s[31:0]), 80'h0000_8001);
        tick();
        bus_s = mk(LH, 1'b1, 4'd0, 1'b1, 1'b1, 5'd4, 32'h0000_2003, 32'h0000_0110);
        tick(); sample();
        check_val("lh_data", 80'(wb_s[31:0]), 80'hFFFF_8001);

        tick();
        bus_s = mk(5'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd5, 32'h0000_CAFE, 32'h0000_0114);
        tick(); sample();
        check_val("alu_data", 80'(wb_s[31:0]), 80'hCAFE);

        // bubble: stall[3]=Stop, stall[4]=NoStop
        tick();
        stall = 6'b001111;
        bus_s = mk(LW, 1'b1, 4'd0, 1'b1, 1'b1, 5'd6, 32'h0000_3000, 32'h0000_0118);
        tick(); sample();
        check_val("bubble_we", 80'(wb_s[37]), 80'd0);
        check_val("bubble_wb", 80'(wb_s), 80'd0);
        stall = 6'd0;
        bus_s = '0;

        // async: sw is posted
        tick();
        bus_a = mk(5'd0, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_4000, 32'h0000_0200);
        tick(); sample();
        check_val("sw_sreq", 80'(sreq_a), 80'd0);
        check_val("sw_we", 80'(wb_a[37]), 80'd0);

        // async lw, data_ok on the 4th MEM cycle
        tick();
        rdata = 32'h0;
        bus_a = mk(LW, 1'b1, 4'd0, 1'b1, 1'b1, 5'd7, 32'h0000_3000, 32'h0000_0204);
        for (int i = 0; i < 3; i++) begin
            tick(); sample();
            check_val($sformatf("wait_sreq%0d", i), 80'(sreq_a), 80'd1);
            check_val($sformatf("wait_fwd_we%0d", i), 80'(fwd_a[37]), 80'd0);
        end
        tick();
        data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
        sample();
        check_val("ok_sreq", 80'(sreq_a), 80'd0);
        check_val("ok_data", 80'(wb_a[31:0]), 80'hDEAD_BEEF);
        check_val("ok_fwd_we", 80'(fwd_a[37]), 80'd1);
        bus_a = mk(LW, 1'b1, 4'd0, 1'b1, 1'b1, 5'd9, 32'h0000_3004, 32'h0000_0208);

        // second lw, data_ok while MEM frozen, then HOLD
        tick();
        data_ok = 1'b0; rdata = 32'h0;
        sample();
        check_val("ld2_sreq", 80'(sreq_a), 80'd1);
        stall = 6'b011111;
        tick(); tick();
        data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
        sample();
        check_val("hold_in_data", 80'(wb_a[31:0]), 80'hDEAD_BEEF);
        check_val("hold_in_sreq", 80'(sreq_a), 80'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            data_ok = 1'b0; rdata = 32'h0;
            sample();
            check_val($sformatf("hold_data%0d", i), 80'(wb_a[31:0]), 80'hDEAD_BEEF);
            check_val($sformatf("hold_sreq%0d", i), 80'(sreq_a), 80'd0);
        end
        tick();
        stall = 6'd0; bus_a = '0;
        sample();
        check_val("release_data", 80'(wb_a[31:0]), 80'hDEAD_BEEF);
        check_val("release_waddr", 80'(wb_a[36:32]), 80'd9);
        tick(); sample();
        check_val("after_release_wb", 80'(wb_a), 80'd0);

        // reset while waiting, then stray data_ok
        tick();
        bus_a = mk(LW, 1'b1, 4'd0, 1'b1, 1'b1, 5'd10, 32'h0000_5000, 32'h0000_0300);
        tick(); tick(); sample();
        check_val("pre_rst_sreq", 80'(sreq_a), 80'd1);
        tick();
        rst = 1'b1; bus_a = '0;
        tick();
        rst = 1'b0; data_ok = 1'b1; rdata = 32'h5555_AAAA;
        sample();
        check_val("rst_mid_wb", 80'(wb_a), 80'd0);
        check_val("rst_mid_fwd", 80'(fwd_a), 80'd0);
        check_val("rst_mid_sreq", 80'(sreq_a), 80'd0);
        tick();
        data_ok = 1'b0;
        sample();
        check_val("late_ok_wb", 80'(wb_a), 80'd0);
        check_val("late_ok_sreq", 80'(sreq_a), 80'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
